// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath width, canonical NOP,
// default reset PC and the {pc, instr} fetch-entry payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Contents of an unoccupied queue slot, so the head always shows a NOP.
  localparam fetch_entry_t FETCH_EMPTY = '{pc: '0, instr: INSTR_NOP};

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry shifting FIFO of fetch entries; slot 0 is the head.
// Ports:
//   clk, rst       - clock, synchronous active-low reset
//   push_i         - write push_data_i into the first free slot
//   pop_i          - drop the head (ignored when empty)
//   flush_i        - empty the queue; wins over push and pop
//   push_data_i    - entry to write
//   head_o         - head entry (registered; FETCH_EMPTY when empty)
//   head_valid_o   - head entry is occupied
//   count_o        - occupancy 0..2
module fetch_queue
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output fetch_entry_t head_o,
  output logic         head_valid_o,
  output logic [1:0]   count_o
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   vld_q, vld_d;

  // Next-state: pop shifts slot 1 forward, push then fills the first free slot.
  // Free slots are reloaded with FETCH_EMPTY so the head needs no output mux.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    vld_d   = vld_q;
    if (flush_i) begin
      slot0_d = FETCH_EMPTY;
      slot1_d = FETCH_EMPTY;
      vld_d   = 2'b00;
    end else begin
      if (pop_i && vld_q[0]) begin
        slot0_d = slot1_q;
        slot1_d = FETCH_EMPTY;
        vld_d   = {1'b0, vld_q[1]};
      end
      if (push_i) begin
        if (!vld_d[0]) begin
          slot0_d  = push_data_i;
          vld_d[0] = 1'b1;
        end else begin
          slot1_d  = push_data_i;
          vld_d[1] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot0_q <= FETCH_EMPTY;
      slot1_q <= FETCH_EMPTY;
      vld_q   <= 2'b00;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      vld_q   <= vld_d;
    end
  end

  assign head_o       = slot0_q;
  assign head_valid_o = vld_q[0];
  assign count_o      = 2'(vld_q[0]) + 2'(vld_q[1]);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC generation, instr_mem read issue, capture into a 2-entry
// queue and valid/ready hand-off to decode, with execute redirects.
// Optional feature macro: IFETCH_MISALIGN_EN (misaligned-redirect exception).
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   fetch_en        - allow new reads (low: drain only)
//   imem_rd_en      - read strobe (combinational)
//   imem_rd_addr    - word address pc[ADDR_W+1:2]
//   imem_rd_instr   - read data, valid the cycle after imem_rd_en
//   redirect_valid  - execute redirect request
//   redirect_pc     - redirect target
//   id_valid/id_ready/id_instr/id_pc - registered decode handshake
//   misalign_exc, misalign_pc        - only with IFETCH_MISALIGN_EN
module instr_fetch #(
  parameter int unsigned         XLEN     = riscv_pkg::XLEN,
  parameter int unsigned         ADDR_W   = 10,
  parameter logic [XLEN-1:0]     RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_rd_addr,
  input  logic [XLEN-1:0]   imem_rd_instr,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [XLEN-1:0]   id_instr,
  output logic [XLEN-1:0]   id_pc
`ifdef IFETCH_MISALIGN_EN
  ,
  output logic              misalign_exc,
  output logic [XLEN-1:0]   misalign_pc
`endif
);

  import riscv_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ipc_q, ipc_d;      // PC of the read in flight
  logic            inflight_q, inflight_d;

  logic            pop, issue, push, blocked;
  logic [2:0]      occupancy;
  logic [XLEN-1:0] target;
  logic [1:0]      q_count;
  logic            head_valid;
  fetch_entry_t    head, push_data;

`ifdef IFETCH_MISALIGN_EN
  logic            mexc_q, mexc_d;
  logic [XLEN-1:0] mpc_q, mpc_d;
  logic            misaligned;

  // A misaligned target is loaded verbatim and parks fetch until re-aligned.
  always_comb begin
    misaligned = (redirect_pc[1:0] != 2'b00);
    target     = misaligned ? redirect_pc : (redirect_pc & ~XLEN'(3));
    blocked    = mexc_q;
    mexc_d     = mexc_q;
    mpc_d      = mpc_q;
    if (redirect_valid) begin
      mexc_d = misaligned;
      mpc_d  = misaligned ? redirect_pc : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mexc_q <= 1'b0;
      mpc_q  <= '0;
    end else begin
      mexc_q <= mexc_d;
      mpc_q  <= mpc_d;
    end
  end

  assign misalign_exc = mexc_q;
  assign misalign_pc  = mpc_q;
`else
  // Low target bits are simply dropped.
  always_comb begin
    target  = redirect_pc & ~XLEN'(3);
    blocked = 1'b0;
  end
`endif

  // Issue only if the queue can still absorb every read already committed.
  always_comb begin
    pop       = head_valid && id_ready;
    occupancy = 3'(q_count) + 3'(inflight_q);
    issue     = rst && fetch_en && !redirect_valid && !blocked &&
                (occupancy < (3'd2 + 3'(pop)));
    push      = inflight_q && !redirect_valid;
    push_data = '{pc: ipc_q, instr: imem_rd_instr};
  end

  // PC / in-flight next state; a redirect discards the outstanding read.
  always_comb begin
    pc_d       = pc_q;
    ipc_d      = ipc_q;
    inflight_d = 1'b0;
    if (redirect_valid) begin
      pc_d = target;
    end else if (issue) begin
      pc_d       = pc_q + XLEN'(4);
      ipc_d      = pc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .push_data_i  (push_data),
    .head_o       (head),
    .head_valid_o (head_valid),
    .count_o      (q_count)
  );

  assign imem_rd_en   = issue;
  assign imem_rd_addr = pc_q[ADDR_W+1:2];
  assign id_valid     = head_valid;
  assign id_instr     = head.instr;
  assign id_pc        = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed latency/stall/redirect/reset/wrap cases,
// then randomized traffic. The reference model is the fetch contract itself:
// after each reset or redirect, decode must see a gapless stream of
// consecutive PCs from the target, each paired with that word of memory.
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam logic [31:0] RPC       = 32'hFFFF_FFF0;
  localparam int          EXP_DEPTH = 1200;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, id_ready;
  logic        imem_rd_en, id_valid;
  logic [9:0]  imem_rd_addr;
  logic [31:0] imem_rd_instr, redirect_pc, id_instr, id_pc;
`ifdef IFETCH_MISALIGN_EN
  logic        misalign_exc;
  logic [31:0] misalign_pc;
  logic        exp_mexc;
  logic [31:0] exp_mpc;
`endif

  instr_fetch #(.XLEN(32), .ADDR_W(10), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_rd_en     (imem_rd_en),
    .imem_rd_addr   (imem_rd_addr),
    .imem_rd_instr  (imem_rd_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
`ifdef IFETCH_MISALIGN_EN
    ,
    .misalign_exc   (misalign_exc),
    .misalign_pc    (misalign_pc)
`endif
  );

  always #5 clk = ~clk;

  // instr_mem stand-in: data one cycle after the strobe, garbage otherwise.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (imem_rd_en) imem_rd_instr <= mem[imem_rd_addr];
    else            imem_rd_instr <= $urandom;
  end

  int           total = 0;
  int           bad   = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rebuild(input logic [31:0] start);
    logic [31:0]  p;
    fetch_entry_t e;
    exp_q.delete();
    for (int i = 0; i < EXP_DEPTH; i++) begin
      p       = start + 32'(4 * i);
      e.pc    = p;
      e.instr = mem[p[11:2]];
      exp_q.push_back(e);
    end
  endtask

  // Apply the model effect of the cycle that just ended (inputs still hold it).
  task automatic settle();
    if (rst !== 1'b1) begin
      rebuild(RPC);
`ifdef IFETCH_MISALIGN_EN
      exp_mexc = 1'b0;
      exp_mpc  = '0;
`endif
    end else if (redirect_valid) begin
`ifdef IFETCH_MISALIGN_EN
      if (redirect_pc[1:0] != 2'b00) begin
        exp_q.delete();
        exp_mexc = 1'b1;
        exp_mpc  = redirect_pc;
      end else begin
        rebuild(redirect_pc);
        exp_mexc = 1'b0;
        exp_mpc  = '0;
      end
`else
      rebuild({redirect_pc[31:2], 2'b00});
`endif
    end
  endtask

  task automatic cyc(input logic r, input logic fe, input logic rv,
                     input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    settle();
    rst            = r;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
  endtask

  // Monitor: every accepted instruction is popped from the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (id_valid === 1'b1 && id_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_instr: got pc %h want no instruction at %0t", id_pc, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("id_pc", id_pc, mon_e.pc);
          chk("id_instr", id_instr, mon_e.instr);
        end
      end else if (id_valid !== 1'b1) begin
        chk("idle_nop", id_instr, INSTR_NOP);
      end
`ifdef IFETCH_MISALIGN_EN
      chk("misalign_exc", 32'(misalign_exc), 32'(exp_mexc));
      chk("misalign_pc", misalign_pc, exp_mpc);
`endif
    end
  end

  initial begin
    logic [31:0] t;
    logic [31:0] base_w;
    logic        r, rv;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + 32'(i);
    base_w = RPC >> 2;
    rst = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; id_ready = 1'b0;

    // Reset state
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_instr", id_instr, INSTR_NOP);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_rd_en", 32'(imem_rd_en), 32'h0);
`ifdef IFETCH_MISALIGN_EN
    chk("rst_mexc", 32'(misalign_exc), 32'h0);
`endif

    // Stream from reset with address wrap 3FC..3FF,000
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("stream_rd_en", 32'(imem_rd_en), 32'h1);
      chk("stream_addr", 32'(imem_rd_addr), (base_w + 32'(k)) & 32'h3FF);
      chk("stream_valid", 32'(id_valid), (k >= 2) ? 32'h1 : 32'h0);
    end

    // Decode stall: queue fills, reads stop
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("stall_rd_en", 32'(imem_rd_en), 32'h0);
      chk("stall_valid", 32'(id_valid), 32'h1);
    end
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect to 0x40 from steady state
    cyc(1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    @(negedge clk);
    chk("redir_rd_en_r", 32'(imem_rd_en), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("redir_rd_en_r1", 32'(imem_rd_en), 32'h1);
    chk("redir_addr_r1", 32'(imem_rd_addr), 32'h10);
    chk("redir_valid_r1", 32'(id_valid), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("redir_valid_r2", 32'(id_valid), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("redir_valid_r3", 32'(id_valid), 32'h1);
    chk("redir_pc_r3", id_pc, 32'h40);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("redir_pc_r4", id_pc, 32'h44);

    // Reset with a full queue
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    chk("full_before_rst", 32'(id_valid), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("post_rst_valid", 32'(id_valid), 32'h0);
    chk("post_rst_instr", id_instr, INSTR_NOP);
    chk("post_rst_addr", 32'(imem_rd_addr), base_w & 32'h3FF);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("restart_pc", id_pc, RPC);

`ifdef IFETCH_MISALIGN_EN
    // Misaligned redirect parks fetch; aligned redirect resumes
    cyc(1'b1, 1'b1, 1'b1, 32'h42, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      chk("mis_rd_en", 32'(imem_rd_en), 32'h0);
      chk("mis_exc_hold", 32'(misalign_exc), 32'h1);
      chk("mis_pc_hold", misalign_pc, 32'h42);
    end
    cyc(1'b1, 1'b1, 1'b1, 32'h80, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("mis_clear", 32'(misalign_exc), 32'h0);
    chk("mis_resume_addr", 32'(imem_rd_addr), 32'h20);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("mis_resume_pc", id_pc, 32'h80);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) != 0);
      rv = ($urandom_range(0, 11) == 0);
      t  = $urandom;
      if ($urandom_range(0, 1) == 1) t = {20'hFFFFF, t[11:0]};
`ifdef IFETCH_MISALIGN_EN
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
`endif
      cyc(r, ($urandom_range(0, 7) != 0), rv, t, ($urandom_range(0, 3) != 0));
    end
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of `instr_mem`. It holds the program counter and issues word-aligned reads to `instr_mem`. It captures the synchronous read data into a 2-entry queue and presents instruction/PC pairs to decode over a valid/ready handshake. It accepts redirects from execute (branches and jumps) and sustains one instruction per cycle when decode never stalls.

## Interface
Parameters:
- `XLEN`, 32, PC and instruction width.
- `ADDR_W`, 10, word-address width of `instr_mem`.
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `fetch_en` in 1: permits new reads; low means drain only.
- `imem_rd_en` out 1: read strobe to `instr_mem`.
- `imem_rd_addr` out ADDR_W: word address, equal to `pc[ADDR_W+1:2]`.
- `imem_rd_instr` in XLEN: read data, valid the cycle after `imem_rd_en`.
- `redirect_valid` in 1: execute requests a PC change.
- `redirect_pc` in XLEN: redirect target.
- `id_valid` out 1: queue head is valid.
- `id_ready` in 1: decode accepts the head.
- `id_instr` out XLEN: head instruction; NOP 32'h0000_0013 when `id_valid`=0.
- `id_pc` out XLEN: PC of the head instruction.
- `misalign_exc` out 1: present only with `IFETCH_MISALIGN_EN`.
- `misalign_pc` out XLEN: present only with `IFETCH_MISALIGN_EN`.

## Operation
- **State:** `pc`; `inflight` flag (a read was issued last cycle); queue of {pc, instr} with `count` 0..2.
- **Pop:** `pop = id_valid && id_ready`; it removes the head at the clock edge.
- **Issue:** `issue = fetch_en && !redirect_valid && (count + inflight - pop) < 2`.
  - On issue, `imem_rd_en`=1 for the current `pc`.
  - At the edge, `pc <= pc + 4`, wrapping modulo 2^XLEN, and `inflight <= 1`.
  - The address wraps naturally through the `ADDR_W` slice.
- **Capture:** if `inflight` is set and there is no redirect this cycle, push {issued pc, `imem_rd_instr`} at the edge.
  - The issue rule guarantees the queue never overflows.
- **Redirect** (`redirect_valid`=1), at the edge:
  - flush the queue (`count <= 0`);
  - drop any in-flight data (not pushed);
  - `inflight <= 0`;
  - `pc <= {redirect_pc[XLEN-1:2], 2'b00}`.
  - A pop that occurs in the same cycle still completes for decode; the flush overrides it for the queue.
- **`fetch_en` low:** no new issues; an in-flight read still lands; the queue drains through decode.
- **Push and pop in the same cycle:** both take effect, so `count` is unchanged.

## Timing
- **Reset** (`rst`=0 at an edge):
  - `pc`=RESET_PC, `count`=0, `inflight`=0;
  - `id_valid`=0, `id_instr`=NOP, `id_pc`=0;
  - `imem_rd_en`=0, `misalign_exc`=0, `misalign_pc`=0.
- **First read:** issued in the first cycle with `rst`=1 and `fetch_en`=1.
- **Read to decode latency:** `imem_rd_en` in cycle N → data sampled at the end of N+1 → `id_valid` in N+2.
- **Redirect to first valid instruction:** redirect in cycle R → read of the target in R+1 → `id_valid` in R+3.
- **Throughput:** steady state is `count`=1, `inflight`=1, one pop per cycle, giving 1 instruction per cycle.
- **Decode stall:** the queue fills to 2 with `inflight`=0, and `imem_rd_en` stays low until a pop.
- **Output registration:**
  - `id_*` are registered queue-head outputs with no combinational path from `imem_rd_instr`.
  - `imem_rd_en` is combinational from state plus `fetch_en`, `redirect_valid` and `id_ready`.
- **Reset mid-operation:** overrides everything, including a redirect in the same cycle; in-flight data is discarded.

## Configuration
- **`IFETCH_MISALIGN_EN` defined:**
  - A redirect with `redirect_pc[1:0]`≠0 flushes the queue as usual and loads `pc` with the target unmodified.
  - It sets `misalign_exc`=1 and `misalign_pc`=`redirect_pc`, and blocks issue.
  - Those values hold until an aligned redirect clears them and fetch resumes at that target.
- **Not defined:** `redirect_pc[1:0]` is ignored (forced to 00); the misalign ports and logic are absent.

## Structure
- **Package `riscv_pkg`:** `XLEN`, `INSTR_NOP` (32'h0000_0013), `RESET_PC` default, and a fetch-entry typedef {pc, instr}.
- **Sub-module `fetch_queue`:**
  - 2-entry FIFO of fetch entries.
  - Ports: push, pop, flush, head, count.
  - Flush has priority over push.

## Test plan
- **Reset and stream:** reset, then `fetch_en`=1 and `id_ready`=1 with mem[k]=k+0x100 → `id_valid` from cycle 2, pcs 0,4,8,… and instr 0x100,0x101,…, one per cycle.
- **Decode stall:** `id_ready`=0 for 5 cycles mid-stream → queue holds 2 entries, `imem_rd_en`=0, no instruction lost or duplicated on resume.
- **Redirect:** `redirect_valid` with pc 0x40 while `count`=1 and `inflight`=1 → both discarded, next `id_pc` is 0x40 three cycles later, then 0x44.
- **Wrap:** RESET_PC=0xFFFF_FFF8 → `id_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; `imem_rd_addr` wraps 0x3FE, 0x3FF, 0x000.
- **Reset mid-stream:** `rst`=0 for 1 cycle with a full queue → `id_valid`=0 next cycle, stream restarts at RESET_PC.
- **Misaligned redirect (`IFETCH_MISALIGN_EN`):** redirect to 0x42 → `misalign_exc`=1 and `misalign_pc`=0x42, no reads; an aligned redirect to 0x80 → exception cleared, fetch resumes at 0x80.
